// File: rtl/ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_master_arbiter
// Purpose  : Two-master AHB-Lite arbiter (M0 = imem, M1 = dmem) onto one
//            shared bus. Each master has a one-entry request buffer that
//            holds an address phase which could not be issued at once.
//            The data-phase owner steers hwdata, hresp and hready.
// Macro    : SCR1_AHB_ARB_RR_EN - defined: round-robin on contention;
//            undefined: fixed priority, M1 always wins contention.
// Ports    : clk, rst_n (sync, active-low)
//            m0_*/m1_* : master-side address/control/wdata in, hready/hresp out
//            m_hrdata  : read data broadcast to both masters
//            haddr, htrans, hwrite, hsize, hwdata : shared bus outputs
//            hready, hresp, hrdata                 : shared bus inputs
// Revision : 1.0 - initial release
// ============================================================================
module ahb_master_arbiter #(
    parameter logic [31:0] ARB_BUF_RESET_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m0_haddr,
    input  logic [1:0]  m0_htrans,
    input  logic        m0_hwrite,
    input  logic [2:0]  m0_hsize,
    input  logic [31:0] m0_hwdata,
    output logic        m0_hready,
    output logic        m0_hresp,
    input  logic [31:0] m1_haddr,
    input  logic [1:0]  m1_htrans,
    input  logic        m1_hwrite,
    input  logic [2:0]  m1_hsize,
    input  logic [31:0] m1_hwdata,
    output logic        m1_hready,
    output logic        m1_hresp,
    output logic [31:0] m_hrdata,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic        hresp,
    input  logic [31:0] hrdata
);

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;

    // Data-phase owner; the state encoding doubles as dp_owner.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_buf_valid_0, r_buf_valid_1;
    logic [31:0] r_buf_addr_0,  r_buf_addr_1;
    logic        r_buf_write_0, r_buf_write_1;
    logic [2:0]  r_buf_size_0,  r_buf_size_1;
    logic [31:0] r_haddr_hold;
    logic        r_hwrite_hold;
    logic [2:0]  r_hsize_hold;
`ifdef SCR1_AHB_ARB_RR_EN
    logic        r_last_grant;  // 0 = M0 issued last, 1 = M1 issued last
`endif

    logic        w_live_0, w_live_1;
    logic        w_req_0,  w_req_1;
    logic        w_grant_0, w_grant_1;
    logic [31:0] w_addr_0, w_addr_1;
    logic [1:0]  w_trans_0, w_trans_1;
    logic        w_write_0, w_write_1;
    logic [2:0]  w_size_0,  w_size_1;

    // A pending buffer stalls its master; otherwise the owner sees the bus.
    assign m0_hready = r_buf_valid_0 ? 1'b0 : ((r_state == ST_OWN0) ? hready : 1'b1);
    assign m1_hready = r_buf_valid_1 ? 1'b0 : ((r_state == ST_OWN1) ? hready : 1'b1);

    // htrans[1] set means NONSEQ or SEQ.
    assign w_live_0 = m0_htrans[1] & m0_hready;
    assign w_live_1 = m1_htrans[1] & m1_hready;
    assign w_req_0  = r_buf_valid_0 | w_live_0;
    assign w_req_1  = r_buf_valid_1 | w_live_1;

    // Buffered request takes precedence over the live one. A replayed burst
    // beat is restarted as NONSEQ because the bus may have changed hands.
    assign w_addr_0  = r_buf_valid_0 ? r_buf_addr_0    : m0_haddr;
    assign w_write_0 = r_buf_valid_0 ? r_buf_write_0   : m0_hwrite;
    assign w_size_0  = r_buf_valid_0 ? r_buf_size_0    : m0_hsize;
    assign w_trans_0 = r_buf_valid_0 ? c_HTRANS_NONSEQ : m0_htrans;
    assign w_addr_1  = r_buf_valid_1 ? r_buf_addr_1    : m1_haddr;
    assign w_write_1 = r_buf_valid_1 ? r_buf_write_1   : m1_hwrite;
    assign w_size_1  = r_buf_valid_1 ? r_buf_size_1    : m1_hsize;
    assign w_trans_1 = r_buf_valid_1 ? c_HTRANS_NONSEQ : m1_htrans;

    always_comb begin
        w_grant_0 = 1'b0;
        w_grant_1 = 1'b0;
        if (hready) begin
            if (w_req_0 && w_req_1) begin
`ifdef SCR1_AHB_ARB_RR_EN
                w_grant_0 = r_last_grant;
                w_grant_1 = ~r_last_grant;
`else
                w_grant_1 = 1'b1;
`endif
            end else begin
                w_grant_0 = w_req_0;
                w_grant_1 = w_req_1;
            end
        end
    end

    always_comb begin
        htrans = c_HTRANS_IDLE;
        haddr  = r_haddr_hold;
        hwrite = r_hwrite_hold;
        hsize  = r_hsize_hold;
        if (w_grant_0) begin
            htrans = w_trans_0;
            haddr  = w_addr_0;
            hwrite = w_write_0;
            hsize  = w_size_0;
        end else if (w_grant_1) begin
            htrans = w_trans_1;
            haddr  = w_addr_1;
            hwrite = w_write_1;
            hsize  = w_size_1;
        end
    end

    always_comb begin
        hwdata   = 32'h0;
        m0_hresp = 1'b0;
        m1_hresp = 1'b0;
        case (r_state)
            ST_OWN0: begin
                hwdata   = m0_hwdata;
                m0_hresp = hresp;
            end
            ST_OWN1: begin
                hwdata   = m1_hwdata;
                m1_hresp = hresp;
            end
            default: ;
        endcase
    end

    assign m_hrdata = hrdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_buf_valid_0 <= 1'b0;
            r_buf_valid_1 <= 1'b0;
            r_buf_addr_0  <= ARB_BUF_RESET_ADDR;
            r_buf_addr_1  <= ARB_BUF_RESET_ADDR;
            r_buf_write_0 <= 1'b0;
            r_buf_write_1 <= 1'b0;
            r_buf_size_0  <= 3'd0;
            r_buf_size_1  <= 3'd0;
            r_haddr_hold  <= 32'h0;
            r_hwrite_hold <= 1'b0;
            r_hsize_hold  <= 3'd0;
`ifdef SCR1_AHB_ARB_RR_EN
            r_last_grant  <= 1'b0;
`endif
        end else begin
            if (hready) begin
                if (w_grant_0) begin
                    r_state       <= ST_OWN0;
                    r_haddr_hold  <= w_addr_0;
                    r_hwrite_hold <= w_write_0;
                    r_hsize_hold  <= w_size_0;
                end else if (w_grant_1) begin
                    r_state       <= ST_OWN1;
                    r_haddr_hold  <= w_addr_1;
                    r_hwrite_hold <= w_write_1;
                    r_hsize_hold  <= w_size_1;
                end else begin
                    r_state       <= ST_IDLE;
                end
            end
`ifdef SCR1_AHB_ARB_RR_EN
            if (w_grant_0)      r_last_grant <= 1'b0;
            else if (w_grant_1) r_last_grant <= 1'b1;
`endif
            // A live request implies an empty buffer (its hready would be 0
            // otherwise), so issue-from-buffer and capture never collide.
            if (w_grant_0 && r_buf_valid_0) begin
                r_buf_valid_0 <= 1'b0;
            end else if (w_live_0 && !w_grant_0) begin
                r_buf_valid_0 <= 1'b1;
                r_buf_addr_0  <= m0_haddr;
                r_buf_write_0 <= m0_hwrite;
                r_buf_size_0  <= m0_hsize;
            end
            if (w_grant_1 && r_buf_valid_1) begin
                r_buf_valid_1 <= 1'b0;
            end else if (w_live_1 && !w_grant_1) begin
                r_buf_valid_1 <= 1'b1;
                r_buf_addr_1  <= m1_haddr;
                r_buf_write_1 <= m1_hwrite;
                r_buf_size_1  <= m1_hsize;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_master_arbiter
// Purpose  : Directed self-checking bench for ahb_master_arbiter. Inputs are
//            driven on the falling edge; outputs are checked 1 time unit later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_master_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_haddr,  m1_haddr;
    logic [1:0]  m0_htrans, m1_htrans;
    logic        m0_hwrite, m1_hwrite;
    logic [2:0]  m0_hsize,  m1_hsize;
    logic [31:0] m0_hwdata, m1_hwdata;
    logic        m0_hready, m1_hready;
    logic        m0_hresp,  m1_hresp;
    logic [31:0] m_hrdata;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;

    int n_cmp = 0;
    int n_err = 0;

    ahb_master_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_haddr  (m0_haddr),
        .m0_htrans (m0_htrans),
        .m0_hwrite (m0_hwrite),
        .m0_hsize  (m0_hsize),
        .m0_hwdata (m0_hwdata),
        .m0_hready (m0_hready),
        .m0_hresp  (m0_hresp),
        .m1_haddr  (m1_haddr),
        .m1_htrans (m1_htrans),
        .m1_hwrite (m1_hwrite),
        .m1_hsize  (m1_hsize),
        .m1_hwdata (m1_hwdata),
        .m1_hready (m1_hready),
        .m1_hresp  (m1_hresp),
        .m_hrdata  (m_hrdata),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hresp     (hresp),
        .hrdata    (hrdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of sequence");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        m0_htrans = 2'b00;
        m1_htrans = 2'b00;
    endtask

    task automatic req0(input logic [31:0] a, input logic w);
        m0_haddr = a; m0_htrans = 2'b10; m0_hwrite = w; m0_hsize = 3'd2;
    endtask

    task automatic req1(input logic [31:0] a, input logic w);
        m1_haddr = a; m1_htrans = 2'b10; m1_hwrite = w; m1_hsize = 3'd2;
    endtask

    logic [31:0] exp_addr;

    initial begin
        rst_n = 1'b0;
        m0_haddr = 32'h0; m0_htrans = 2'b00; m0_hwrite = 1'b0; m0_hsize = 3'd0; m0_hwdata = 32'h0;
        m1_haddr = 32'h0; m1_htrans = 2'b00; m1_hwrite = 1'b0; m1_hsize = 3'd0; m1_hwdata = 32'h0;
        hready = 1'b1; hresp = 1'b0; hrdata = 32'hA5A5_0001;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        // Reset state
        check("rst_htrans",    {30'd0, htrans}, 32'd0);
        check("rst_haddr",     haddr, 32'h0);
        check("rst_hwrite",    {31'd0, hwrite}, 32'd0);
        check("rst_hsize",     {29'd0, hsize}, 32'd0);
        check("rst_hwdata",    hwdata, 32'h0);
        check("rst_m0_hready", {31'd0, m0_hready}, 32'd1);
        check("rst_m1_hready", {31'd0, m1_hready}, 32'd1);
        check("rst_m0_hresp",  {31'd0, m0_hresp}, 32'd0);
        check("rst_m1_hresp",  {31'd0, m1_hresp}, 32'd0);
        check("hrdata_pass",   m_hrdata, 32'hA5A5_0001);

        // Single requester, zero latency
        req0(32'h100, 1'b0);
        #1;
        check("s1_haddr",  haddr, 32'h100);
        check("s1_htrans", {30'd0, htrans}, 32'd2);
        @(negedge clk);
        idle_all(); hready = 1'b0;
        #1;
        check("s1_m0_hready_wait", {31'd0, m0_hready}, 32'd0);
        check("s1_idle_on_wait",   {30'd0, htrans}, 32'd0);
        check("s1_haddr_hold",     haddr, 32'h100);
        hready = 1'b1;
        #1;
        check("s1_m0_hready_go",   {31'd0, m0_hready}, 32'd1);
        @(negedge clk);

        // Simultaneous requests: M1 first, M0 buffered then issued
        req0(32'h100, 1'b0); req1(32'h2000_0000, 1'b0);
        #1;
        check("s2_haddr_m1",  haddr, 32'h2000_0000);
        check("s2_htrans_m1", {30'd0, htrans}, 32'd2);
        @(negedge clk);
        idle_all();
        #1;
        check("s2_m0_hready_buf", {31'd0, m0_hready}, 32'd0);
        check("s2_m1_hready",     {31'd0, m1_hready}, 32'd1);
        check("s2_haddr_m0",      haddr, 32'h100);
        check("s2_htrans_m0",     {30'd0, htrans}, 32'd2);
        @(negedge clk);
        #1;
        check("s2_no_dup",        {30'd0, htrans}, 32'd0);
        check("s2_m0_hready_own", {31'd0, m0_hready}, 32'd1);
        @(negedge clk);

        // Continuous contention: one M1 transfer first so round-robin starts at M0
        req1(32'h300, 1'b0);
        #1;
        check("s3_pre_haddr", haddr, 32'h300);
        @(negedge clk);
        idle_all();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            req0(32'h100, 1'b0); req1(32'h200, 1'b0);
`ifdef SCR1_AHB_ARB_RR_EN
            exp_addr = (i % 2 == 0) ? 32'h100 : 32'h200;
`else
            exp_addr = 32'h200;
`endif
            #1;
            check($sformatf("s3_grant%0d", i), haddr, exp_addr);
            @(negedge clk);
        end
        idle_all();
        #1;
        check("s3_drain_haddr",  haddr, 32'h100);
        check("s3_drain_htrans", {30'd0, htrans}, 32'd2);
        @(negedge clk);
        #1;
        check("s3_drained", {30'd0, htrans}, 32'd0);
        @(negedge clk);

        // M1 write with two wait states
        m0_hwdata = 32'h1234_5678;
        req1(32'h400, 1'b1);
        #1;
        check("s4_haddr",  haddr, 32'h400);
        check("s4_hwrite", {31'd0, hwrite}, 32'd1);
        @(negedge clk);
        idle_all(); m1_hwdata = 32'hDEAD_BEEF; hready = 1'b0;
        #1;
        check("s4_hwdata_w1", hwdata, 32'hDEAD_BEEF);
        check("s4_hready_w1", {31'd0, m1_hready}, 32'd0);
        @(negedge clk);
        #1;
        check("s4_hwdata_w2", hwdata, 32'hDEAD_BEEF);
        check("s4_hready_w2", {31'd0, m1_hready}, 32'd0);
        @(negedge clk);
        hready = 1'b1;
        #1;
        check("s4_hwdata_w3", hwdata, 32'hDEAD_BEEF);
        check("s4_hready_w3", {31'd0, m1_hready}, 32'd1);
        @(negedge clk);
        #1;
        check("s4_hwdata_none", hwdata, 32'h0);

        // Two-cycle ERROR on an M0 transfer
        req0(32'h500, 1'b0);
        #1;
        check("s5_haddr", haddr, 32'h500);
        @(negedge clk);
        idle_all(); hready = 1'b0; hresp = 1'b1;
        #1;
        check("s5_m0_hresp_c1",  {31'd0, m0_hresp}, 32'd1);
        check("s5_m0_hready_c1", {31'd0, m0_hready}, 32'd0);
        check("s5_m1_hresp_c1",  {31'd0, m1_hresp}, 32'd0);
        @(negedge clk);
        hready = 1'b1;
        #1;
        check("s5_m0_hresp_c2",  {31'd0, m0_hresp}, 32'd1);
        check("s5_m0_hready_c2", {31'd0, m0_hready}, 32'd1);
        check("s5_m1_hresp_c2",  {31'd0, m1_hresp}, 32'd0);
        @(negedge clk);
        hresp = 1'b0;
        #1;
        check("s5_m0_hresp_end", {31'd0, m0_hresp}, 32'd0);

        // Reset with M0 buffered
        req0(32'h600, 1'b0); req1(32'h700, 1'b0);
        #1;
        check("s6_haddr_m1", haddr, 32'h700);
        @(negedge clk);
        idle_all();
        #1;
        check("s6_m0_buffered", {31'd0, m0_hready}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("s6_htrans",    {30'd0, htrans}, 32'd0);
        check("s6_haddr",     haddr, 32'h0);
        check("s6_m0_hready", {31'd0, m0_hready}, 32'd1);
        check("s6_m1_hready", {31'd0, m1_hready}, 32'd1);
        @(negedge clk);
        #1;
        check("s6_buf_empty", {30'd0, htrans}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
